feature_uart_tx: RTL

Transmits the audio front end's 26-word mean/std feature vector to a host as one checksummed UART frame. It sits downstream of the feature FIFO in the audio-processing top level. It is the reading end of that FIFO's parallel output vector. When triggered, it snapshots all 26 words and serializes them as an 8N1 byte stream on a single TX line.

---
 rtl/feature_uart_tx.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/feature_uart_tx.sv
// feature_uart_tx: snapshots an N_WORDS x 16-bit feature vector on start and sends it
// as one 8N1 UART frame: sync byte, high/low byte per word, then an XOR checksum.
module feature_uart_tx #(
  parameter int         CLKS_PER_BIT = 868,
  parameter int         N_WORDS      = 26,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [N_WORDS-1:0][15:0] feature_in,
  output logic                    tx,
  output logic                    busy,
  output logic                    done
);

  localparam int N_BYTES = 2 * N_WORDS + 2;
  localparam int IDX_W   = $clog2(N_BYTES);
  localparam int WORD_W  = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam int BAUD_W  = $clog2(CLKS_PER_BIT);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_BYTES - 1);
  localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START_BIT, DATA_BITS, STOP_BIT} state_t;

  state_t                     state, state_next;
  logic [BAUD_W-1:0]          baud_cnt;
  logic [2:0]                 bit_cnt;
  logic [IDX_W-1:0]           byte_idx;
  logic [7:0]                 cur_byte;
  logic [7:0]                 checksum;
  logic [N_WORDS-1:0][15:0]   shadow;
  logic                       tx_reg, tx_next;
  logic                       done_reg, done_next;
  logic                       advance;
  logic                       baud_wrap;

  logic [IDX_W-1:0]  next_idx;
  logic [WORD_W-1:0] word_sel;
  logic [15:0]       word_val;
  logic [7:0]        next_byte;
  logic              next_is_data;

  assign baud_wrap = (baud_cnt == BAUD_MAX);

  // Byte index i (1..2N) maps to word (i-1)/2; the current index is exactly i-1 of the next byte.
  always_comb begin
    next_idx     = byte_idx + IDX_W'(1);
    word_sel     = WORD_W'(byte_idx >> 1);
    word_val     = shadow[word_sel];
    next_is_data = (next_idx != LAST_IDX);
    next_byte    = next_is_data ? (byte_idx[0] ? word_val[7:0] : word_val[15:8]) : checksum;
  end

  always_comb begin
    state_next = state;
    tx_next    = tx_reg;
    done_next  = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        // A start in the cycle done is high belongs to the frame just finished.
        if (start && !done_reg) begin
          state_next = START_BIT;
          tx_next    = 1'b0;
        end
      end
      START_BIT: begin
        if (baud_wrap) begin
          state_next = DATA_BITS;
          tx_next    = cur_byte[0];
        end
      end
      DATA_BITS: begin
        if (baud_wrap) begin
          if (bit_cnt == 3'd7) begin
            state_next = STOP_BIT;
            tx_next    = 1'b1;
          end else begin
            tx_next = cur_byte[bit_cnt + 3'd1];
          end
        end
      end
      STOP_BIT: begin
        if (baud_wrap) begin
          if (byte_idx < LAST_IDX) begin
            state_next = START_BIT;
            tx_next    = 1'b0;
            advance    = 1'b1;
          end else begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx_reg   <= 1'b1;
      done_reg <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      byte_idx <= '0;
      checksum <= '0;
      cur_byte <= '0;
    end else begin
      state    <= state_next;
      tx_reg   <= tx_next;
      done_reg <= done_next;
      if (state == IDLE) begin
        baud_cnt <= '0;
        bit_cnt  <= '0;
        if (state_next == START_BIT) begin
          byte_idx <= '0;
          checksum <= '0;
          cur_byte <= SYNC_BYTE;
        end
      end else begin
        baud_cnt <= baud_wrap ? '0 : baud_cnt + BAUD_W'(1);
        if (state == DATA_BITS && baud_wrap) begin
          bit_cnt <= bit_cnt + 3'd1;
        end
        if (advance) begin
          byte_idx <= next_idx;
          cur_byte <= next_byte;
          if (next_is_data) begin
            checksum <= checksum ^ next_byte;
          end
        end
      end
    end
  end

  // The snapshot is only captured on an accepted start, so it needs no reset.
  always_ff @(posedge clk) begin
    if (!rst && state == IDLE && state_next == START_BIT) begin
      shadow <= feature_in;
    end
  end

  assign tx   = tx_reg;
  assign busy = (state != IDLE);
  assign done = done_reg;

endmodule
